// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, optional parity and one or two stop bits.
// The serial line is double-flopped; data, parity and stop bits are sampled mid-bit.
module uart_rx #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned N_DATA          = 8,
    parameter int unsigned PARITY_CHECK    = 0,
    parameter int unsigned EVEN_ODD_PARITY = 1,
    parameter int unsigned M_STOP          = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err
);
    localparam int unsigned N_SAMPLES = N_DATA + PARITY_CHECK;
    localparam int unsigned NB_BIT    = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              r_state, w_state_next;
    logic                r_sync1, r_sync2;
    logic [3:0]          r_tick, w_tick_next;
    logic [NB_BIT-1:0]   r_bit, w_bit_next;
    logic [1:0]          r_stop, w_stop_next;
    logic [N_DATA-1:0]   r_shift, w_shift_next;
    logic                r_par, w_par_next;
    logic                r_ferr_acc, w_ferr_acc_next;
    logic                r_wait_high, w_wait_high_next;
    logic [NB_DATA-1:0]  r_data, w_data_next;
    logic                r_done, w_done_next;
    logic                r_perr, w_perr_next;
    logic                r_ferr, w_ferr_next;
    logic                w_line, w_par_exp, w_frame_bad;

    assign w_line      = r_sync2;
    assign w_par_exp   = (EVEN_ODD_PARITY != 0) ? ^r_shift : ~^r_shift;
    assign w_frame_bad = r_ferr_acc | ~w_line;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_stop      <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_ferr_acc  <= 1'b0;
            r_wait_high <= 1'b1;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1     <= i_data;
            r_sync2     <= r_sync1;
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_bit       <= w_bit_next;
            r_stop      <= w_stop_next;
            r_shift     <= w_shift_next;
            r_par       <= w_par_next;
            r_ferr_acc  <= w_ferr_acc_next;
            r_wait_high <= w_wait_high_next;
            r_data      <= w_data_next;
            r_done      <= w_done_next;
            r_perr      <= w_perr_next;
            r_ferr      <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tick_next      = r_tick;
        w_bit_next       = r_bit;
        w_stop_next      = r_stop;
        w_shift_next     = r_shift;
        w_par_next       = r_par;
        w_ferr_acc_next  = r_ferr_acc;
        w_wait_high_next = r_wait_high;
        w_data_next      = r_data;
        w_done_next      = 1'b0;
        w_perr_next      = r_perr;
        w_ferr_next      = r_ferr;
        if (i_valid) begin
            unique case (r_state)
                IDLE: begin
                    // After a framing error or reset the line must read high before a new start bit counts
                    if (r_wait_high) begin
                        if (w_line) w_wait_high_next = 1'b0;
                    end else if (!w_line) begin
                        w_state_next = START;
                        w_tick_next  = '0;
                    end
                end
                START: begin
                    if (r_tick == 4'd7) begin
                        w_tick_next = '0;
                        if (!w_line) begin
                            w_state_next    = DATA;
                            w_bit_next      = '0;
                            w_ferr_acc_next = 1'b0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                DATA: begin
                    if (r_tick == 4'd15) begin
                        w_tick_next = '0;
                        if (r_bit < NB_BIT'(N_DATA)) w_shift_next = {w_line, r_shift[N_DATA-1:1]};
                        else                         w_par_next   = w_line;
                        if (r_bit == NB_BIT'(N_SAMPLES - 1)) begin
                            w_state_next = STOP;
                            w_stop_next  = '0;
                        end else begin
                            w_bit_next = r_bit + NB_BIT'(1);
                        end
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                STOP: begin
                    if (r_tick == 4'd15) begin
                        w_tick_next     = '0;
                        w_ferr_acc_next = w_frame_bad;
                        if (r_stop == 2'(M_STOP - 1)) begin
                            w_state_next     = IDLE;
                            w_done_next      = 1'b1;
                            w_data_next      = NB_DATA'(r_shift);
                            w_perr_next      = (PARITY_CHECK != 0) && (r_par != w_par_exp);
                            w_ferr_next      = w_frame_bad;
                            w_wait_high_next = w_frame_bad;
                        end else begin
                            w_stop_next = r_stop + 2'd1;
                        end
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_rx_done    = r_done;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default instance and an even-parity, two-stop-bit instance,
// driven with a vector table, directed corner sequences and random frames.
module tb_uart_rx;
    logic       i_clock = 1'b0;
    logic       i_reset, i_valid, rx0, rx1;
    logic [7:0] data0, data1;
    logic       done0, done1, perr0, perr1, ferr0, ferr1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned div      = 1;
    bit          jitter   = 1'b0;
    int unsigned wide0    = 0;
    int unsigned wide1    = 0;
    logic        prev0    = 1'b0;
    logic        prev1    = 1'b0;
    // {instance, data, parity_err, frame_err}
    logic [10:0] got[$];
    logic [10:0] expq[$];

    typedef struct {
        int unsigned inst;
        logic [7:0]  data;
        logic        pbit;
        logic [1:0]  stops;
        int unsigned div;
        logic [7:0]  e_data;
        logic        e_perr;
        logic        e_ferr;
    } vec_t;
    vec_t vecs[10];

    always #5 i_clock = ~i_clock;

    uart_rx dut0 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_data(rx0),
        .o_data(data0), .o_rx_done(done0), .o_parity_err(perr0), .o_frame_err(ferr0)
    );

    uart_rx #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(1), .M_STOP(2)) dut1 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_data(rx1),
        .o_data(data1), .o_rx_done(done1), .o_parity_err(perr1), .o_frame_err(ferr1)
    );

    always @(negedge i_clock) begin
        if (done0) begin
            got.push_back({1'b0, data0, perr0, ferr0});
            if (prev0) wide0++;
        end
        if (done1) begin
            got.push_back({1'b1, data1, perr1, ferr1});
            if (prev1) wide1++;
        end
        prev0 <= done0;
        prev1 <= done1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_ticks(input int unsigned n);
        for (int unsigned t = 0; t < n; t++) begin
            int unsigned idle;
            idle = jitter ? $urandom_range(0, 2) : div - 1;
            i_valid = 1'b1;
            @(negedge i_clock);
            i_valid = 1'b0;
            repeat (idle) @(negedge i_clock);
        end
    endtask

    task automatic set_line(input int unsigned inst, input logic v);
        if (inst == 0) rx0 = v;
        else           rx1 = v;
    endtask

    task automatic send_frame(input int unsigned inst, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stops);
        set_line(inst, 1'b0);
        do_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_line(inst, d[i]);
            do_ticks(16);
        end
        if (inst == 1) begin
            set_line(inst, pbit);
            do_ticks(16);
        end
        set_line(inst, stops[0]);
        do_ticks(16);
        if (inst == 1) begin
            set_line(inst, stops[1]);
            do_ticks(16);
        end
        set_line(inst, 1'b1);
    endtask

    // Expected result from the frame as transmitted: even parity over the byte, any low stop bit is an error
    function automatic logic [10:0] model(input int unsigned inst, input logic [7:0] d,
                                          input logic pbit, input logic [1:0] stops);
        logic pe, fe;
        if (inst == 0) begin
            pe = 1'b0;
            fe = (stops[0] == 1'b0);
        end else begin
            pe = (pbit != (($countones(d) % 2) == 1));
            fe = (stops != 2'b11);
        end
        return {inst[0], d, pe, fe};
    endfunction

    task automatic expect_one(input string name, input int unsigned inst, input logic [7:0] d,
                              input logic pe, input logic fe);
        logic [10:0] r;
        check({name, "_count"}, 32'(got.size()), 32'd1);
        if (got.size() > 0) begin
            r = got.pop_front();
            check({name, "_src"}, 32'(r[10]), 32'(inst[0]));
            check({name, "_data"}, 32'(r[9:2]), 32'(d));
            check({name, "_perr"}, 32'(r[1]), 32'(pe));
            check({name, "_ferr"}, 32'(r[0]), 32'(fe));
        end
        got.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data0"}, 32'(data0), 32'd0);
        check({name, "_done0"}, 32'(done0), 32'd0);
        check({name, "_perr0"}, 32'(perr0), 32'd0);
        check({name, "_ferr0"}, 32'(ferr0), 32'd0);
        check({name, "_data1"}, 32'(data1), 32'd0);
        check({name, "_perr1"}, 32'(perr1), 32'd0);
        check({name, "_ferr1"}, 32'(ferr1), 32'd0);
    endtask

    initial begin
        logic [7:0]  b2b[3];
        logic [7:0]  d;
        logic [1:0]  st;
        logic        pb;
        logic [10:0] e;
        int unsigned inst;
        int unsigned n;

        vecs[0] = '{0, 8'h55, 1'b0, 2'b11, 1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{1, 8'hA3, 1'b0, 2'b11, 1, 8'hA3, 1'b0, 1'b0};
        vecs[2] = '{1, 8'hA3, 1'b1, 2'b11, 1, 8'hA3, 1'b1, 1'b0};
        vecs[3] = '{0, 8'h00, 1'b0, 2'b11, 2, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{0, 8'hFF, 1'b0, 2'b11, 4, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h00, 1'b1, 2'b11, 3, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h07, 1'b1, 2'b11, 1, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{0, 8'hC3, 1'b0, 2'b10, 1, 8'hC3, 1'b0, 1'b1};
        vecs[8] = '{1, 8'h81, 1'b0, 2'b01, 2, 8'h81, 1'b0, 1'b1};
        vecs[9] = '{1, 8'h6E, 1'b0, 2'b10, 1, 8'h6E, 1'b1, 1'b1};

        i_reset = 1'b1;
        i_valid = 1'b0;
        rx0     = 1'b1;
        rx1     = 1'b1;
        repeat (3) @(negedge i_clock);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        do_ticks(20);

        for (int i = 0; i < 10; i++) begin
            div = vecs[i].div;
            send_frame(vecs[i].inst, vecs[i].data, vecs[i].pbit, vecs[i].stops);
            do_ticks(20);
            expect_one($sformatf("vec%0d", i), vecs[i].inst, vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr);
        end

        // Start-bit glitch must be rejected without touching the outputs
        div = 1;
        send_frame(0, 8'h96, 1'b0, 2'b11);
        do_ticks(20);
        expect_one("pre_glitch", 0, 8'h96, 1'b0, 1'b0);
        rx0 = 1'b0;
        do_ticks(4);
        rx0 = 1'b1;
        do_ticks(40);
        check("glitch_count", 32'(got.size()), 32'd0);
        check("glitch_data", 32'(data0), 32'h96);

        // Framing error followed by a held-low break: one frame only
        send_frame(0, 8'h3C, 1'b0, 2'b00);
        rx0 = 1'b0;
        do_ticks(64);
        expect_one("break", 0, 8'h3C, 1'b0, 1'b1);
        rx0 = 1'b1;
        do_ticks(20);
        send_frame(0, 8'h42, 1'b0, 2'b11);
        do_ticks(20);
        expect_one("after_break", 0, 8'h42, 1'b0, 1'b0);

        // Back-to-back frames with a tick every 4th clock
        div    = 4;
        b2b[0] = 8'h01;
        b2b[1] = 8'h80;
        b2b[2] = 8'hFF;
        for (int i = 0; i < 3; i++) send_frame(0, b2b[i], 1'b0, 2'b11);
        do_ticks(20);
        check("b2b_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (got.size() > 0) begin
                e = got.pop_front();
                check($sformatf("b2b%0d", i), 32'(e), 32'({1'b0, b2b[i], 1'b0, 1'b0}));
            end
        end
        got.delete();
        check("pulse_width0", 32'(wide0), 32'd0);

        // Reset during data bit 4
        div = 1;
        d   = 8'h5A;
        rx0 = 1'b0;
        do_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx0 = d[i];
            do_ticks(16);
        end
        rx0 = d[4];
        do_ticks(8);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        check_reset_outputs("midreset");
        i_reset = 1'b0;
        rx0     = 1'b1;
        do_ticks(20);
        check("midreset_nopulse", 32'(got.size()), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        do_ticks(20);
        expect_one("after_reset", 0, 8'h5A, 1'b0, 1'b0);

        // Random frames with irregular tick spacing against the reference model
        jitter = 1'b1;
        expq.delete();
        for (int i = 0; i < 40; i++) begin
            inst = $urandom_range(0, 1);
            d    = 8'($urandom);
            pb   = 1'($urandom_range(0, 1));
            st   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            e    = model(inst, d, pb, st);
            expq.push_back(e);
            send_frame(inst, d, pb, st);
            if (e[0]) do_ticks(16 * $urandom_range(1, 2));
            else      do_ticks(16 * $urandom_range(0, 1));
        end
        do_ticks(20);
        check("rand_count", 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int unsigned i = 0; i < n; i++)
            check($sformatf("rand%0d", i), 32'(got[i]), 32'(expq[i]));
        check("pulse_width1", 32'(wide1), 32'd0);
        check("pulse_width0_end", 32'(wide0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
